// File: rtl/enc_8b10b_tx_if.sv
// Byte-in / symbol-out bus of the 8B/10B transmit encoder.
// master: TX datapath side (drives byte requests, observes symbols).
// slave : encoder side.
interface enc_8b10b_tx_if;
    logic       in_valid;
    logic       k_in;
    logic [7:0] in;
    logic [9:0] out;
    logic       out_valid;
    logic       idle_out;
    logic       rdispout;
    logic       code_err;

    modport master (
        output in_valid, k_in, in,
        input  out, out_valid, idle_out, rdispout, code_err
    );

    modport slave (
        input  in_valid, k_in, in,
        output out, out_valid, idle_out, rdispout, code_err
    );
endinterface

// File: rtl/enc_8b10b_tx.sv
// Registered 8B/10B encoder with running-disparity tracking.
// One symbol per clock, 1-cycle latency. Symbol bit order is
// {j,h,g,f,i,e,d,c,b,a}; out[0] (a) goes on the wire first.
// Illegal K requests are sent as the D code of the byte and flagged.
// With IDLE_COMMA set, cycles without a request carry K28.5.
module enc_8b10b_tx #(
    parameter bit INIT_RD    = 1'b0,
    parameter bit IDLE_COMMA = 1'b1
) (
    input  logic          clock,
    input  logic          reset,
    enc_8b10b_tx_if.slave bus
);

    // 5b/6b table, RD- form, written abcdei with a in bit 5.
    function automatic logic [5:0] lut6_neg(input logic [4:0] x);
        logic [5:0] c;
        case (x)
            5'd0:    c = 6'b100111;
            5'd1:    c = 6'b011101;
            5'd2:    c = 6'b101101;
            5'd3:    c = 6'b110001;
            5'd4:    c = 6'b110101;
            5'd5:    c = 6'b101001;
            5'd6:    c = 6'b011001;
            5'd7:    c = 6'b111000;
            5'd8:    c = 6'b111001;
            5'd9:    c = 6'b100101;
            5'd10:   c = 6'b010101;
            5'd11:   c = 6'b110100;
            5'd12:   c = 6'b001101;
            5'd13:   c = 6'b101100;
            5'd14:   c = 6'b011100;
            5'd15:   c = 6'b010111;
            5'd16:   c = 6'b011011;
            5'd17:   c = 6'b100011;
            5'd18:   c = 6'b010011;
            5'd19:   c = 6'b110010;
            5'd20:   c = 6'b001011;
            5'd21:   c = 6'b101010;
            5'd22:   c = 6'b011010;
            5'd23:   c = 6'b111010;
            5'd24:   c = 6'b110011;
            5'd25:   c = 6'b100110;
            5'd26:   c = 6'b010110;
            5'd27:   c = 6'b110110;
            5'd28:   c = 6'b001110;
            5'd29:   c = 6'b101110;
            5'd30:   c = 6'b011110;
            default: c = 6'b101011;
        endcase
        return c;
    endfunction

    // 3b/4b table, RD- form, written fghj with f in bit 3.
    function automatic logic [3:0] lut4_neg(input logic [2:0] y, input logic alt7);
        logic [3:0] c;
        case (y)
            3'd0:    c = 4'b1011;
            3'd1:    c = 4'b1001;
            3'd2:    c = 4'b0101;
            3'd3:    c = 4'b1100;
            3'd4:    c = 4'b1101;
            3'd5:    c = 4'b1010;
            3'd6:    c = 4'b0110;
            default: c = alt7 ? 4'b0111 : 4'b1110;
        endcase
        return c;
    endfunction

    // Tables are written first-bit-leftmost; the bus wants first bit at index 0.
    function automatic logic [5:0] rev6(input logic [5:0] v);
        return {v[0], v[1], v[2], v[3], v[4], v[5]};
    endfunction

    function automatic logic [3:0] rev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    logic       enc_k;
    logic [7:0] enc_byte;
    logic [4:0] x;
    logic [2:0] y;
    logic       is_k28;
    logic       is_kx7;
    logic       legal_k;
    logic [5:0] base6;
    logic [5:0] code6;
    logic       rd_mid;
    logic       use_a7;
    logic [3:0] base4;
    logic [3:0] code4;
    logic       rd_sym;
    logic [9:0] sym;

    logic [9:0] out_q,       out_d;
    logic       out_valid_q, out_valid_d;
    logic       idle_q,      idle_d;
    logic       code_err_q,  code_err_d;
    logic       rd_q,        rd_d;

    // Symbol lookup for the current request (K28.5 substituted on empty cycles).
    always_comb begin
        enc_k    = bus.k_in;
        enc_byte = bus.in;
        if (!bus.in_valid) begin
            enc_k    = 1'b1;
            enc_byte = 8'hBC;
        end
        x = enc_byte[4:0];
        y = enc_byte[7:5];

        is_k28  = enc_k && (x == 5'd28);
        is_kx7  = enc_k && (y == 3'd7) &&
                  ((x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30));
        legal_k = is_k28 || is_kx7;

        // 6b: unbalanced codes and D.7 take the complemented form at RD+.
        base6  = is_k28 ? 6'b001111 : lut6_neg(x);
        code6  = base6;
        if (rd_q && (($countones(base6) != 3) || (!is_k28 && (x == 5'd7))))
            code6 = ~base6;
        rd_mid = rd_q ^ ($countones(base6) != 3);

        // A7 avoids a run of five across the 6b/4b boundary; K.x.7 always uses it.
        use_a7 = (y == 3'd7) &&
                 (legal_k ||
                  (!rd_mid && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
                  ( rd_mid && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))));
        base4  = lut4_neg(y, use_a7);
        code4  = base4;
        if (rd_mid && (($countones(base4) != 2) || (y == 3'd3)))
            code4 = ~base4;
        // K28 inverts its balanced 4b codes when following the RD- side 6b (110000).
        if (is_k28 && !rd_mid &&
            ((y == 3'd1) || (y == 3'd2) || (y == 3'd5) || (y == 3'd6)))
            code4 = ~base4;
        rd_sym = rd_mid ^ ($countones(base4) != 2);

        sym = {rev4(code4), rev6(code6)};
    end

    // Next state of the output stage: load a symbol, load a comma, or hold.
    always_comb begin
        out_d       = out_q;
        rd_d        = rd_q;
        out_valid_d = 1'b0;
        idle_d      = 1'b0;
        code_err_d  = 1'b0;
        if (bus.in_valid) begin
            out_d       = sym;
            rd_d        = rd_sym;
            out_valid_d = 1'b1;
            code_err_d  = bus.k_in && !legal_k;
        end else if (IDLE_COMMA) begin
            out_d  = sym;
            rd_d   = rd_sym;
            idle_d = 1'b1;
        end
    end

    // Output register and running disparity; reset wipes any symbol in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            idle_q      <= 1'b0;
            code_err_q  <= 1'b0;
            rd_q        <= INIT_RD;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            idle_q      <= idle_d;
            code_err_q  <= code_err_d;
            rd_q        <= rd_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.idle_out  = idle_q;
    assign bus.code_err  = code_err_q;
    assign bus.rdispout  = rd_q;

endmodule

// File: tb/tb_enc_8b10b_tx.sv
// Testbench for enc_8b10b_tx: directed symbol vectors plus a stream
// sweep over all D codes and legal K codes with disparity/run-length checks.
module tb_enc_8b10b_tx;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic rd_model = 1'b0;

    enc_8b10b_tx_if bus0();
    enc_8b10b_tx_if bus1();

    enc_8b10b_tx #(.INIT_RD(1'b0), .IDLE_COMMA(1'b1)) dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (bus0)
    );

    enc_8b10b_tx #(.INIT_RD(1'b1), .IDLE_COMMA(1'b0)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       v;
        logic       k;
        logic [7:0] b;
        logic [9:0] sym;
        logic       rd;
        logic       ov;
        logic       idle;
        logic       err;
    } vec_t;

    // Converts abcdei_fghj notation to the bus bit order {j..f,i..a}.
    function automatic logic [9:0] S(input logic [5:0] abcdei, input logic [3:0] fghj);
        logic [9:0] r;
        for (int i = 0; i < 6; i++) r[i] = abcdei[5-i];
        for (int i = 0; i < 4; i++) r[6+i] = fghj[3-i];
        return r;
    endfunction

    task automatic drive0(input logic v, input logic k, input logic [7:0] b);
        bus0.in_valid = v;
        bus0.k_in     = k;
        bus0.in       = b;
        @(posedge clock);
        #1;
    endtask

    task automatic drive1(input logic v, input logic k, input logic [7:0] b);
        bus1.in_valid = v;
        bus1.k_in     = k;
        bus1.in       = b;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [13:0] got;
        bus0.in_valid = 1'b1; bus0.k_in = 1'b0; bus0.in = 8'h00;
        bus1.in_valid = 1'b1; bus1.k_in = 1'b0; bus1.in = 8'h00;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        got = {bus0.out, bus0.rdispout, bus0.out_valid, bus0.idle_out, bus0.code_err};
        n_tests++;
        if (got !== 14'b0) begin
            n_fail++;
            $display("FAIL reset_dut0 {out,rd,ov,idle,err} got %b exp %b", got, 14'b0);
        end
        got = {bus1.out, bus1.rdispout, bus1.out_valid, bus1.idle_out, bus1.code_err};
        n_tests++;
        if (got !== {10'b0, 1'b1, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_dut1 {out,rd,ov,idle,err} got %b exp %b", got, {10'b0, 1'b1, 3'b000});
        end
        bus0.in = 8'hB5;
        bus1.in_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    // dut1 has no idle commas and starts at RD+; dut0 gets balanced D21.5 meanwhile.
    task automatic test_hold();
        vec_t        tv[5];
        logic [13:0] got, exp;
        bus0.in_valid = 1'b1; bus0.k_in = 1'b0; bus0.in = 8'hB5;
        tv[0] = '{1'b1, 1'b0, 8'h00, S(6'b011000, 4'b1011), 1'b1, 1'b1, 1'b0, 1'b0};
        tv[1] = '{1'b0, 1'b0, 8'h00, S(6'b011000, 4'b1011), 1'b1, 1'b0, 1'b0, 1'b0};
        tv[2] = '{1'b0, 1'b1, 8'hBC, S(6'b011000, 4'b1011), 1'b1, 1'b0, 1'b0, 1'b0};
        tv[3] = '{1'b0, 1'b0, 8'h55, S(6'b011000, 4'b1011), 1'b1, 1'b0, 1'b0, 1'b0};
        tv[4] = '{1'b1, 1'b0, 8'hB5, S(6'b101010, 4'b1010), 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive1(tv[i].v, tv[i].k, tv[i].b);
            got = {bus1.out, bus1.rdispout, bus1.out_valid, bus1.idle_out, bus1.code_err};
            exp = {tv[i].sym, tv[i].rd, tv[i].ov, tv[i].idle, tv[i].err};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL hold[%0d] {out,rd,ov,idle,err} got %b exp %b", i, got, exp);
            end
        end
        bus1.in_valid = 1'b0;
    endtask

    task automatic test_data();
        vec_t        tv[8];
        logic [13:0] got, exp;
        tv[0] = '{1'b1, 1'b0, 8'h00, S(6'b100111, 4'b0100), 1'b0, 1'b1, 1'b0, 1'b0};
        tv[1] = '{1'b1, 1'b0, 8'hF1, S(6'b100011, 4'b0111), 1'b1, 1'b1, 1'b0, 1'b0};
        tv[2] = '{1'b1, 1'b0, 8'hB5, S(6'b101010, 4'b1010), 1'b1, 1'b1, 1'b0, 1'b0};
        tv[3] = '{1'b1, 1'b0, 8'hEB, S(6'b110100, 4'b1000), 1'b0, 1'b1, 1'b0, 1'b0};
        tv[4] = '{1'b1, 1'b0, 8'h67, S(6'b111000, 4'b1100), 1'b0, 1'b1, 1'b0, 1'b0};
        tv[5] = '{1'b1, 1'b0, 8'h03, S(6'b110001, 4'b1011), 1'b1, 1'b1, 1'b0, 1'b0};
        tv[6] = '{1'b1, 1'b0, 8'h67, S(6'b000111, 4'b0011), 1'b1, 1'b1, 1'b0, 1'b0};
        tv[7] = '{1'b1, 1'b0, 8'hF1, S(6'b100011, 4'b0001), 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            drive0(tv[i].v, tv[i].k, tv[i].b);
            got = {bus0.out, bus0.rdispout, bus0.out_valid, bus0.idle_out, bus0.code_err};
            exp = {tv[i].sym, tv[i].rd, tv[i].ov, tv[i].idle, tv[i].err};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL data[%0d] {out,rd,ov,idle,err} got %b exp %b", i, got, exp);
            end
        end
    endtask

    task automatic test_k_codes();
        vec_t        tv[6];
        logic [13:0] got, exp;
        tv[0] = '{1'b1, 1'b1, 8'hBC, S(6'b001111, 4'b1010), 1'b1, 1'b1, 1'b0, 1'b0};
        tv[1] = '{1'b1, 1'b1, 8'hBC, S(6'b110000, 4'b0101), 1'b0, 1'b1, 1'b0, 1'b0};
        tv[2] = '{1'b1, 1'b1, 8'hF7, S(6'b111010, 4'b1000), 1'b0, 1'b1, 1'b0, 1'b0};
        tv[3] = '{1'b1, 1'b1, 8'hFC, S(6'b001111, 4'b1000), 1'b0, 1'b1, 1'b0, 1'b0};
        tv[4] = '{1'b1, 1'b1, 8'h3C, S(6'b001111, 4'b1001), 1'b1, 1'b1, 1'b0, 1'b0};
        tv[5] = '{1'b1, 1'b1, 8'h3C, S(6'b110000, 4'b0110), 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            drive0(tv[i].v, tv[i].k, tv[i].b);
            got = {bus0.out, bus0.rdispout, bus0.out_valid, bus0.idle_out, bus0.code_err};
            exp = {tv[i].sym, tv[i].rd, tv[i].ov, tv[i].idle, tv[i].err};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL kcode[%0d] {out,rd,ov,idle,err} got %b exp %b", i, got, exp);
            end
        end
    endtask

    task automatic test_illegal_k();
        vec_t        tv[3];
        logic [13:0] got, exp;
        tv[0] = '{1'b1, 1'b1, 8'h00, S(6'b100111, 4'b0100), 1'b0, 1'b1, 1'b0, 1'b1};
        tv[1] = '{1'b1, 1'b0, 8'h00, S(6'b100111, 4'b0100), 1'b0, 1'b1, 1'b0, 1'b0};
        tv[2] = '{1'b1, 1'b1, 8'hFF, S(6'b101011, 4'b0001), 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            drive0(tv[i].v, tv[i].k, tv[i].b);
            got = {bus0.out, bus0.rdispout, bus0.out_valid, bus0.idle_out, bus0.code_err};
            exp = {tv[i].sym, tv[i].rd, tv[i].ov, tv[i].idle, tv[i].err};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL illegal_k[%0d] {out,rd,ov,idle,err} got %b exp %b", i, got, exp);
            end
        end
    endtask

    task automatic test_idle();
        vec_t        tv[5];
        logic [13:0] got, exp;
        tv[0] = '{1'b0, 1'b0, 8'h00, S(6'b001111, 4'b1010), 1'b1, 1'b0, 1'b1, 1'b0};
        tv[1] = '{1'b0, 1'b1, 8'h00, S(6'b110000, 4'b0101), 1'b0, 1'b0, 1'b1, 1'b0};
        tv[2] = '{1'b0, 1'b0, 8'hF1, S(6'b001111, 4'b1010), 1'b1, 1'b0, 1'b1, 1'b0};
        tv[3] = '{1'b0, 1'b1, 8'hFF, S(6'b110000, 4'b0101), 1'b0, 1'b0, 1'b1, 1'b0};
        tv[4] = '{1'b1, 1'b0, 8'hB5, S(6'b101010, 4'b1010), 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive0(tv[i].v, tv[i].k, tv[i].b);
            got = {bus0.out, bus0.rdispout, bus0.out_valid, bus0.idle_out, bus0.code_err};
            exp = {tv[i].sym, tv[i].rd, tv[i].ov, tv[i].idle, tv[i].err};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL idle[%0d] {out,rd,ov,idle,err} got %b exp %b", i, got, exp);
            end
        end
    endtask

    // Back-to-back stream of every D code then every legal K code.
    task automatic test_back_to_back();
        logic [7:0] kc[12];
        logic [5:0] seen6[2][32];
        bit         seenv[2][32];
        logic [9:0] o;
        logic       rd_m, rd_nx, last_bit;
        int         ones, ones6, run, max_run, xi, ri;
        bit         ok;
        kc = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
               8'hF7, 8'hFB, 8'hFD, 8'hFE};
        for (int r = 0; r < 2; r++)
            for (int j = 0; j < 32; j++) seenv[r][j] = 1'b0;
        rd_m     = 1'b0;
        run      = 0;
        max_run  = 0;
        last_bit = 1'b0;
        for (int i = 0; i < 268; i++) begin
            if (i < 256) drive0(1'b1, 1'b0, 8'(i));
            else         drive0(1'b1, 1'b1, kc[i-256]);
            o     = bus0.out;
            ones  = $countones(o);
            ones6 = $countones(o[5:0]);
            rd_nx = (ones != 5) ? ~rd_m : rd_m;
            n_tests++;
            if (!(bus0.out_valid === 1'b1 && bus0.code_err === 1'b0 && bus0.idle_out === 1'b0)) begin
                n_fail++;
                $display("FAIL stream_flags[%0d] ov/idle/err got %b%b%b exp 100", i,
                         bus0.out_valid, bus0.idle_out, bus0.code_err);
            end
            ok = ((ones == 5) || (!rd_m && ones == 6) || (rd_m && ones == 4)) &&
                 ((ones6 == 3) || (!rd_m && ones6 == 4) || (rd_m && ones6 == 2)) &&
                 (bus0.rdispout === rd_nx);
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL stream_disp[%0d] out %b ones %0d ones6 %0d rd_in %b rd_out %b exp rd_out %b",
                         i, o, ones, ones6, rd_m, bus0.rdispout, rd_nx);
            end
            for (int j = 0; j < 10; j++) begin
                if (o[j] == last_bit) run++;
                else run = 1;
                last_bit = o[j];
                if (run > max_run) max_run = run;
            end
            if (i < 256) begin
                xi = i % 32;
                ri = int'(rd_m);
                if (seenv[ri][xi]) begin
                    n_tests++;
                    if (o[5:0] !== seen6[ri][xi]) begin
                        n_fail++;
                        $display("FAIL stream_6b[%0d] 6b got %b exp %b", i, o[5:0], seen6[ri][xi]);
                    end
                end else begin
                    seen6[ri][xi] = o[5:0];
                    seenv[ri][xi] = 1'b1;
                end
            end
            rd_m = rd_nx;
        end
        n_tests++;
        if (max_run > 5) begin
            n_fail++;
            $display("FAIL stream_runlen got %0d exp <=5", max_run);
        end
        rd_model = rd_m;
    endtask

    task automatic test_reset_mid();
        logic [13:0] got, exp;
        // Bring dut0 to RD+ so the post-reset symbol shows RD went back to RD-.
        if (rd_model == 1'b0) drive0(1'b1, 1'b1, 8'hBC);
        else                  drive0(1'b1, 1'b0, 8'hB5);
        n_tests++;
        if (bus0.rdispout !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_pre rd got %b exp 1", bus0.rdispout);
        end
        bus0.in_valid = 1'b1; bus0.k_in = 1'b0; bus0.in = 8'h00;
        #2;
        reset = 1'b0;
        #1;
        got = {bus0.out, bus0.rdispout, bus0.out_valid, bus0.idle_out, bus0.code_err};
        n_tests++;
        if (got !== 14'b0) begin
            n_fail++;
            $display("FAIL reset_mid_async {out,rd,ov,idle,err} got %b exp %b", got, 14'b0);
        end
        @(posedge clock);
        #1;
        got = {bus0.out, bus0.rdispout, bus0.out_valid, bus0.idle_out, bus0.code_err};
        n_tests++;
        if (got !== 14'b0) begin
            n_fail++;
            $display("FAIL reset_mid_held {out,rd,ov,idle,err} got %b exp %b", got, 14'b0);
        end
        n_tests++;
        if (bus1.rdispout !== 1'b1 || bus1.out !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_mid_dut1 out/rd got %b/%b exp %b/1", bus1.out, bus1.rdispout, 10'b0);
        end
        @(negedge clock);
        reset = 1'b1;
        drive0(1'b1, 1'b0, 8'h00);
        got = {bus0.out, bus0.rdispout, bus0.out_valid, bus0.idle_out, bus0.code_err};
        exp = {S(6'b100111, 4'b0100), 1'b0, 1'b1, 1'b0, 1'b0};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL reset_mid_after {out,rd,ov,idle,err} got %b exp %b", got, exp);
        end
    endtask

    initial begin
        test_reset();
        test_hold();
        test_data();
        test_k_codes();
        test_illegal_k();
        test_idle();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
